serial_frame_tx: RTL and testbench
==================================

# serial_frame_tx

Serial frame transmitter: accepts a W-bit parallel word over a valid/ready handshake and drives it MSB-first onto a single-bit serial line. Each word is preceded by the `1,1,0` frame marker, which the team's Mealy sequence detector recognises. The block sits on the transmit side of that serial link. Its `out` pin feeds the detector's `in` pin directly, and both blocks run on the same `clk`.

## Interface
- `W`, default 8: payload width in bits; legal range 2..32.
- `clk`  in  1: single clock, all logic on its rising edge.
- `clr`  in  1: reset, synchronous, active-high.
- `data`  in  W: payload word, sampled only at accept.
- `load`  in  1: word valid.
- `ready`  out  1: block can accept a word.
- `out`  out  1: serial line, registered.
- `mark`  out  1: high while `out` carries the `0` bit of the frame marker.
- `busy`  out  1: frame in progress.
- `done`  out  1: one-cycle pulse, high while `out` carries the last bit of a frame.

## Operation
- States:
  - IDLE.
  - PRE, 2 bit-cycles, `out`=1.
  - MARK, 1 bit-cycle, `out`=0, `mark`=1.
  - DATA, W bit-cycles, `out`=data MSB-first.
  - PAR, 1 bit-cycle; present only with the macro described under Configuration.
- Accept condition: `load`=1 and `ready`=1 at a rising edge.
  - `data` is copied into the W-bit shift register.
  - The parity accumulator clears.
  - The state moves IDLE→PRE.
- `ready` = 1 only in IDLE. `load` while `ready`=0 is ignored and not queued.
- `data` changes after accept have no effect on the frame in progress.
- DATA state:
  - `out` = shift register MSB.
  - Register shifts left each cycle; zero fill.
  - Bit counter runs 0..W-1. Width is `$clog2(W)` bits, and it never wraps past W-1.
- Transitions:
  - PRE→MARK after 2 cycles.
  - MARK→DATA.
  - DATA→IDLE, or DATA→PAR when the macro is defined, after bit W-1.
  - PAR→IDLE.
- In IDLE, `out`=0. The line idles low, so an idle line can never complete a marker.
- Payload content is unrestricted. Payload bits may themselves form `1,1,0`; the receiver is responsible for frame alignment via `mark` timing.
- `busy` = 1 in every state except IDLE.
- Reset (`clr`=1 at an edge), from any state:
  - State → IDLE; any frame in progress is abandoned.
  - Values after that edge: `out`=0, `mark`=0, `busy`=0, `done`=0, `ready`=1.
  - The shift register and counter clear.
  - `load` in the same cycle as `clr` is ignored.

## Timing
- All outputs are registered or decoded from registered state; there is no combinational path from `load` or `data` to any output.
- Accept at edge T0 → first marker bit on `out` during cycle T0+1.
- Frame length L = W+3 bit-cycles, or W+4 with the macro. Bits occupy cycles T0+1..T0+L.
- `mark`=1 during cycle T0+3. `done`=1 during cycle T0+L only.
- State is IDLE again in cycle T0+L+1, with `ready`=1.
- Back-to-back frames: an accept at edge T0+L+1 puts the next first bit in cycle T0+L+2. This leaves exactly one idle `0` between frames.
- Maximum throughput: one frame per L+1 cycles.

## Configuration
- `SERIAL_TX_PARITY_EN`.
  - Defined: PAR state is compiled in. After the last data bit, `out` = even parity (XOR of all W payload bits) for one cycle, and `done` moves to that cycle.
  - Undefined: no PAR state, L = W+3, and the parity accumulator is not synthesised.

## Test plan
- Reset: hold `clr`=1 for 3 cycles with `load`=1 → `out`=0, `busy`=0, `done`=0, `mark`=0, `ready`=1 throughout; no frame starts.
- Basic frame, W=8, macro undefined: accept `data`=8'hA5 at T0 → `out` over cycles T0+1..T0+11 = 1,1,0,1,0,1,0,0,1,0,1.
  - `mark` high only at T0+3.
  - `done` high only at T0+11.
  - `ready` back to 1 at T0+12.
- Parity, macro defined:
  - 8'hA5 → 12th bit = 0.
  - 8'h07 → 12th bit = 1; `done` at T0+12.
- Ignored load / data hold: pulse `load` with 8'hFF at T0+5 mid-frame, and change `data` after accept → the frame carries the original word and no second frame follows.
- Back-to-back: hold `load`=1 with 8'h00 then 8'hFF → exactly one idle `0` between the last bit of frame 1 and the first `1` of frame 2.
- Mid-frame reset: assert `clr` at T0+6 of an 8'hC3 frame → `out`=0 from T0+7, `busy`=0. A fresh accept afterwards produces a complete frame starting with `1,1,0`.

Source files
------------

// File: rtl/serial_frame_tx.sv
// serial_frame_tx: parallel-to-serial frame transmitter.
// Accepts a W-bit word on load/ready and sends the marker 1,1,0 followed by
// the word MSB-first on 'out'. The line idles low between frames.
//
// Optional feature macro: SERIAL_TX_PARITY_EN
//   defined   -> one extra even-parity bit after the payload; 'done' moves onto it
//   undefined -> frame is marker + payload only (W+3 bit-cycles)
//
// Ports:
//   clk    in   1  rising-edge clock
//   clr    in   1  synchronous active-high reset
//   data   in   W  payload word, sampled only when a word is accepted
//   load   in   1  word valid
//   ready  out  1  high only while idle; load && ready accepts a word
//   out    out  1  registered serial line
//   mark   out  1  high while 'out' carries the marker's 0 bit
//   busy   out  1  high while a frame is in progress
//   done   out  1  high while 'out' carries the last bit of the frame
module serial_frame_tx #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic [W-1:0] data,
    input  logic         load,
    output logic         ready,
    output logic         out,
    output logic         mark,
    output logic         busy,
    output logic         done
);

    localparam int unsigned    CW       = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0]  LAST_BIT = CW'(W - 1);
    localparam logic [CW-1:0]  PRE_LAST = CW'(1);

`ifdef SERIAL_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_PRE, S_MARK, S_DATA, S_PAR} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_PRE, S_MARK, S_DATA} state_t;
`endif

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_next;
    logic [W-1:0]    sreg;
    logic [W-1:0]    sreg_next;
`ifdef SERIAL_TX_PARITY_EN
    logic            par;
    logic            par_next;
`endif

    logic            accept;
    logic            out_d;
    logic            mark_d;
    logic            busy_d;
    logic            done_d;
    logic            ready_d;

    assign accept = load & ready;

    // State, datapath and output registers; reset wins over any accept.
    always_ff @(posedge clk) begin
        if (clr) begin
            state <= S_IDLE;
            cnt   <= '0;
            sreg  <= '0;
`ifdef SERIAL_TX_PARITY_EN
            par   <= 1'b0;
`endif
            out   <= 1'b0;
            mark  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            ready <= 1'b1;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            sreg  <= sreg_next;
`ifdef SERIAL_TX_PARITY_EN
            par   <= par_next;
`endif
            out   <= out_d;
            mark  <= mark_d;
            busy  <= busy_d;
            done  <= done_d;
            ready <= ready_d;
        end
    end

    // Next-state and datapath update. cnt counts preamble bits in PRE and
    // payload bits in DATA, restarting at 0 on each state entry.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        sreg_next  = sreg;
`ifdef SERIAL_TX_PARITY_EN
        par_next   = par;
`endif
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_next = S_PRE;
                    cnt_next   = '0;
                    sreg_next  = data;
`ifdef SERIAL_TX_PARITY_EN
                    par_next   = 1'b0;
`endif
                end
            end
            S_PRE: begin
                if (cnt == PRE_LAST) begin
                    state_next = S_MARK;
                    cnt_next   = '0;
                end else begin
                    cnt_next   = cnt + CW'(1);
                end
            end
            S_MARK: begin
                state_next = S_DATA;
                cnt_next   = '0;
            end
            S_DATA: begin
                // The bit on the line this cycle is sreg[W-1]; fold it into parity.
                sreg_next = {sreg[W-2:0], 1'b0};
`ifdef SERIAL_TX_PARITY_EN
                par_next  = par ^ sreg[W-1];
`endif
                if (cnt == LAST_BIT) begin
`ifdef SERIAL_TX_PARITY_EN
                    state_next = S_PAR;
`else
                    state_next = S_IDLE;
`endif
                    cnt_next   = '0;
                end else begin
                    cnt_next   = cnt + CW'(1);
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            S_PAR: begin
                state_next = S_IDLE;
            end
`endif
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state, so every output is a register
    // that shows the current bit-cycle's value.
    always_comb begin
        out_d   = 1'b0;
        mark_d  = 1'b0;
        done_d  = 1'b0;
        busy_d  = (state_next != S_IDLE);
        ready_d = (state_next == S_IDLE);
        case (state_next)
            S_PRE: begin
                out_d = 1'b1;
            end
            S_MARK: begin
                mark_d = 1'b1;
            end
            S_DATA: begin
                out_d = sreg_next[W-1];
`ifndef SERIAL_TX_PARITY_EN
                done_d = (cnt_next == LAST_BIT);
`endif
            end
`ifdef SERIAL_TX_PARITY_EN
            S_PAR: begin
                out_d  = par_next;
                done_d = 1'b1;
            end
`endif
            default: begin
                out_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// tb_serial_frame_tx: directed bench for serial_frame_tx.
// A frame-level model turns each accepted word into its list of expected
// bit-cycles; a negedge process compares every output against it each cycle.
// Directed tasks add hand-written literal sequences that pin the model.
// Honours SERIAL_TX_PARITY_EN the same way as the design.
module tb_serial_frame_tx;

    localparam int unsigned W = 8;
`ifdef SERIAL_TX_PARITY_EN
    localparam int unsigned L = W + 4;
`else
    localparam int unsigned L = W + 3;
`endif

    logic         clk  = 1'b0;
    logic         clr  = 1'b1;
    logic         load = 1'b0;
    logic [W-1:0] data = '0;
    logic         ready;
    logic         out;
    logic         mark;
    logic         busy;
    logic         done;

    serial_frame_tx #(.W(W)) dut (
        .clk   (clk),
        .clr   (clr),
        .data  (data),
        .load  (load),
        .ready (ready),
        .out   (out),
        .mark  (mark),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic out;
        logic mark;
        logic done;
        logic busy;
        logic ready;
    } exp_t;

    localparam exp_t IDLE_E = '{out: 1'b0, mark: 1'b0, done: 1'b0, busy: 1'b0, ready: 1'b1};

    exp_t cur = IDLE_E;
    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   chk_en   = 1'b0;

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Expected bit-cycles for one frame: marker, payload MSB-first, optional parity.
    function automatic void push_frame(input logic [W-1:0] d);
        logic [L-1:0] bits;
        exp_t         e;
`ifdef SERIAL_TX_PARITY_EN
        bits = {3'b110, d, ^d};
`else
        bits = {3'b110, d};
`endif
        for (int i = 0; i < int'(L); i++) begin
            e.out   = bits[L-1-i];
            e.mark  = (i == 2);
            e.done  = (i == int'(L) - 1);
            e.busy  = 1'b1;
            e.ready = 1'b0;
            exp_q.push_back(e);
        end
    endfunction

    // Model: a word is taken only when the previous cycle showed ready.
    always @(posedge clk) begin
        if (clr) begin
            exp_q.delete();
            cur <= IDLE_E;
        end else begin
            if (load && cur.ready)
                push_frame(data);
            if (exp_q.size() > 0)
                cur <= exp_q.pop_front();
            else
                cur <= IDLE_E;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_out",   out,   cur.out);
            check("cyc_mark",  mark,  cur.mark);
            check("cyc_done",  done,  cur.done);
            check("cyc_busy",  busy,  cur.busy);
            check("cyc_ready", ready, cur.ready);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Accept d, then check the whole frame against a hand-written literal.
    task automatic frame_lit(input string tag, input logic [W-1:0] d, input logic [L-1:0] lit);
        load = 1'b1;
        data = d;
        @(posedge clk);
        #2;
        load = 1'b0;
        data = ~d;
        for (int k = 1; k <= int'(L); k++) begin
            @(negedge clk);
            check({tag, "_out"},       out,      lit[L-k]);
            check({tag, "_model_out"}, cur.out,  lit[L-k]);
            check({tag, "_mark"},      mark,     logic'(k == 3));
            check({tag, "_done"},      done,     logic'(k == int'(L)));
        end
        @(negedge clk);
        check({tag, "_ready_after"}, ready, 1'b1);
        check({tag, "_busy_after"},  busy,  1'b0);
    endtask

    logic [L-1:0] lit;

    initial begin
        // Reset held 3+ cycles with load high: nothing may start.
        clr  = 1'b1;
        load = 1'b1;
        data = 8'h5A;
        tick();
        chk_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_ready", ready, 1'b1);
            check("rst_busy",  busy,  1'b0);
            check("rst_out",   out,   1'b0);
            check("rst_mark",  mark,  1'b0);
            check("rst_done",  done,  1'b0);
            tick();
        end
        clr  = 1'b0;
        load = 1'b0;
        repeat (2) tick();
        check("post_rst_busy", busy, 1'b0);

        // Basic frames.
`ifdef SERIAL_TX_PARITY_EN
        lit = 12'b110_1010_0101_0;
`else
        lit = 11'b110_1010_0101;
`endif
        frame_lit("a5", 8'hA5, lit);
`ifdef SERIAL_TX_PARITY_EN
        lit = 12'b110_0000_0111_1;
`else
        lit = 11'b110_0000_0111;
`endif
        frame_lit("07", 8'h07, lit);
        tick();

        // Mid-frame load is ignored and data changes after accept are harmless.
        load = 1'b1;
        data = 8'h3C;
        tick();
        load = 1'b0;
        data = 8'h00;
        repeat (4) @(posedge clk);
        #2;
        load = 1'b1;
        data = 8'hFF;
        tick();
        load = 1'b0;
        repeat (L + 4) tick();
        check("ign_busy", busy, 1'b0);
        check("ign_out",  out,  1'b0);

        // Back-to-back: load held, 00 then FF; exactly one idle 0 between.
        load = 1'b1;
        data = 8'h00;
        @(posedge clk);
        #2;
        data = 8'hFF;
        for (int k = 1; k <= int'(L) + 2; k++) begin
            @(negedge clk);
            if (k == int'(L)) begin
                check("b2b_last_out", out,  1'b0);
                check("b2b_last_done", done, 1'b1);
            end
            if (k == int'(L) + 1) begin
                check("b2b_gap_out",   out,   1'b0);
                check("b2b_gap_ready", ready, 1'b1);
            end
            if (k == int'(L) + 2) begin
                check("b2b_next_out",  out,  1'b1);
                check("b2b_next_busy", busy, 1'b1);
                load = 1'b0;
            end
        end
        repeat (L + 3) tick();
        check("b2b_idle_busy", busy, 1'b0);

        // Mid-frame reset at T0+6 of a C3 frame.
        load = 1'b1;
        data = 8'hC3;
        tick();
        load = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 6)
                clr = 1'b1;
        end
        @(negedge clk);
        check("mrst_out",   out,   1'b0);
        check("mrst_busy",  busy,  1'b0);
        check("mrst_ready", ready, 1'b1);
        check("mrst_mark",  mark,  1'b0);
        clr = 1'b0;
        repeat (3) tick();
        check("mrst_still_idle", busy, 1'b0);
`ifdef SERIAL_TX_PARITY_EN
        lit = 12'b110_1000_0001_0;
`else
        lit = 11'b110_1000_0001;
`endif
        frame_lit("81", 8'h81, lit);

        // A few more words checked by the model only.
        load = 1'b1;
        data = 8'h5A;
        tick();
        load = 1'b0;
        repeat (L + 2) tick();
        load = 1'b1;
        data = 8'hFE;
        tick();
        load = 1'b0;
        repeat (L + 3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
